uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Receive-side frame controller for the UART RX path. It detects a start condition on the serial line, keeps the per-bit edge counter and bit counter, and issues single-cycle enables to the sampler, start checker, deserializer, parity checker and stop checker. It latches their error results and raises `data_valid` for each error-free frame. It sits between the oversampled `RX_IN` line and the check/deserialize stages; its `par_check_en` output drives the parity-check stage directly.

## Interface
Parameters:
- `Data_size`, default 8: number of data bits per frame; sets the bit-counter range.

Ports:
- `clk` in 1: oversampling clock.
- `rst` in 1: asynchronous, active-low reset.
- `RX_IN` in 1: serial line; idles high.
- `PAR_EN` in 1: a parity bit is present in the frame.
- `prescale` in 6: oversampling ratio; legal values are 8, 16 and 32.
- `strt_glitch` in 1: start-checker result; valid one cycle after `strt_chk_en`.
- `par_err` in 1: parity-checker result; valid one cycle after `par_check_en`.
- `stp_err` in 1: stop-checker result; valid one cycle after `stp_chk_en`.
- `edge_cnt` out 6: current oversample edge within the bit, 0..prescale-1.
- `dat_samp_en` out 1: sampler enable; high in every non-IDLE state.
- `strt_chk_en`, `deser_en`, `par_check_en`, `stp_chk_en` out 1 each: one-cycle check/shift strobes.
- `data_valid` out 1: one-cycle pulse marking an error-free frame.
- `frame_err` out 1: present only with `UART_RX_FSM_FRAME_ERR_EN`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. State encoding is binary, registered.
- Let M = prescale/2 + 2. This is the edge at which the three-sample majority result is valid. Let E = prescale-1.
- IDLE:
  - Counters are held at 0.
  - `RX_IN`==0 at a clock edge moves to START with `edge_cnt`=0.
  - `PAR_EN` and `prescale` are registered at this transition and used for the whole frame.
- `edge_cnt` increments every non-IDLE cycle and wraps E→0. `bit_cnt` increments on that wrap in DATA only.
- START:
  - `strt_chk_en` is high at edge M.
  - At edge M+1, `strt_glitch`=1 returns the FSM to IDLE, with counters cleared.
  - Otherwise the FSM moves to DATA at edge E.
- DATA:
  - `deser_en` is high at edge M of each bit.
  - After bit Data_size-1 completes at edge E, the FSM moves to PARITY if `PAR_EN`, else to STOP.
- PARITY:
  - `par_check_en` is high at edge M.
  - At edge M+1, `par_err` is OR-ed into the internal sticky `err_q`. The parity stage clears `par_err` once its enable drops, so the FSM samples it exactly at M+1.
  - The FSM moves to STOP at edge E.
- STOP:
  - `stp_chk_en` is high at edge M.
  - At edge M+1, `stp_err` is OR-ed into `err_q`.
  - At edge E the FSM goes to IDLE. `data_valid` is registered high for the next cycle iff `err_q`==0.
  - `err_q` clears on entry to START.
- Only one enable strobe can be high in any cycle.

## Timing
- Reset values: state IDLE, `edge_cnt`=0, `bit_cnt`=0, `err_q`=0. All outputs are 0, including `frame_err`.
- Asserting `rst` mid-frame aborts the frame immediately. No `data_valid` is produced for the aborted frame.
- Frame length, from the first START cycle to the first IDLE cycle:
  - prescale×(Data_size+2) cycles without parity.
  - prescale×(Data_size+3) cycles with parity.
- `data_valid` latency: it coincides with the first IDLE cycle after STOP.
- Back-to-back frames: if `RX_IN` is low in that first IDLE cycle, START is entered on the following cycle. This gives one cycle of slack per frame, which is within half a bit at prescale≥8.
- A start glitch returns to IDLE at edge M+2. `RX_IN` still low there starts a new frame.
- Enable strobes are combinational decodes of state and `edge_cnt`. `data_valid` and `frame_err` are registered.
- Changes to `PAR_EN` or `prescale` mid-frame are ignored until the next START.

## Configuration
- `UART_RX_FSM_FRAME_ERR_EN` defined:
  - Adds the output `frame_err`.
  - It is registered and pulses high for one cycle in the same cycle `data_valid` would have pulsed, when `err_q`=1.
  - `data_valid` stays 0 in that case.
- Not defined: the port is absent, and errored frames are dropped silently (no `data_valid`).

## Test plan
- prescale=8, `PAR_EN`=1, frame 0xA5 with even parity bit 0, all checker errors 0 → `deser_en` pulses at edges 6 of bits 0..7; one `par_check_en` and one `stp_chk_en`; `data_valid`=1 exactly 88 cycles after START entry.
- prescale=16, `PAR_EN`=0, 0x3C → no `par_check_en`; `data_valid` at cycle 160 after START entry.
- `strt_glitch`=1 at edge M+1 → IDLE at edge M+2; no `deser_en` or `data_valid`; `edge_cnt`=0.
- `par_err`=1 at PARITY edge M+1 → `data_valid` stays 0. With the macro, `frame_err` pulses once at the same cycle position. The next clean frame then yields `data_valid`=1, proving `err_q` cleared.
- Two frames with `RX_IN` low in the first IDLE cycle → the second START is entered the next cycle; two `data_valid` pulses 89 cycles apart (prescale=8, parity).
- `rst` low during DATA bit 3 → all outputs are 0 asynchronously; after release the FSM stays in IDLE while `RX_IN`=1.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller. It finds the start bit, counts
// oversample edges and data bits, strobes the sampler/checker/deserializer
// stages, and flags each error-free frame with a data_valid pulse.
// Ports:
//   clk, rst (async, active low)   oversampling clock and reset
//   RX_IN, PAR_EN, prescale        serial line, parity present, oversample ratio (8/16/32)
//   strt_glitch, par_err, stp_err  checker results, valid one cycle after their enable
//   edge_cnt                       oversample edge within the current bit
//   dat_samp_en                    sampler enable, high whenever a frame is in progress
//   strt_chk_en, deser_en,
//   par_check_en, stp_chk_en       single-cycle stage strobes
//   data_valid                     registered pulse in the first IDLE cycle of a clean frame
//   frame_err                      only with UART_RX_FSM_FRAME_ERR_EN: pulse for an errored frame
module uart_rx_fsm #(
    parameter int Data_size = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_check_en,
    output logic       stp_chk_en,
`ifdef UART_RX_FSM_FRAME_ERR_EN
    output logic       data_valid,
    output logic       frame_err
`else
    output logic       data_valid
`endif
);
    localparam int BW = $clog2(Data_size + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(Data_size - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        state_q, state_d;
    logic [5:0]    edge_q, edge_d, pre_q, pre_d, mid, last_edge;
    logic [BW-1:0] bit_q, bit_d;
    logic          par_q, par_d, err_q, err_d, dv_q, dv_d;
    logic          last, chk;
`ifdef UART_RX_FSM_FRAME_ERR_EN
    logic          fe_q, fe_d;
`endif
    // Majority vote of the three centre samples is ready at mid; checker
    // results come back one edge later (chk).
    assign mid       = (pre_q >> 1) + 6'd2;
    assign last_edge = pre_q - 6'd1;
    assign last      = edge_q == last_edge;
    assign chk       = edge_q == mid + 6'd1;
    always_comb begin
        state_d = state_q;
        edge_d  = '0;
        bit_d   = bit_q;
        pre_d   = pre_q;
        par_d   = par_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            bit_d = '0;
            if (!RX_IN) begin
                state_d = START;
                pre_d   = prescale;
                par_d   = PAR_EN;
                err_d   = 1'b0;
            end
        end else begin
            edge_d = last ? '0 : edge_q + 6'd1;
            case (state_q)
                START: begin
                    // Glitch has priority: at prescale 8 the check edge is also the last edge.
                    if (chk && strt_glitch) begin
                        state_d = IDLE;
                        edge_d  = '0;
                    end else if (last) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (last) begin
                        bit_d = bit_q + BW'(1);
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = par_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    err_d = err_q | (chk & par_err);
                    if (last) state_d = STOP;
                end
                STOP: begin
                    err_d = err_q | (chk & stp_err);
                    if (last) state_d = IDLE;
                end
                default: ;
            endcase
        end
        // err_d already folds in a stop error sampled on the final edge.
        dv_d = state_q == STOP && last && !err_d;
`ifdef UART_RX_FSM_FRAME_ERR_EN
        fe_d = state_q == STOP && last && err_d;
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            pre_q   <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
`ifdef UART_RX_FSM_FRAME_ERR_EN
            fe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            pre_q   <= pre_d;
            par_q   <= par_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
`ifdef UART_RX_FSM_FRAME_ERR_EN
            fe_q    <= fe_d;
`endif
        end
    end
    assign edge_cnt     = edge_q;
    assign dat_samp_en  = state_q != IDLE;
    assign strt_chk_en  = state_q == START && edge_q == mid;
    assign deser_en     = state_q == DATA && edge_q == mid;
    assign par_check_en = state_q == PARITY && edge_q == mid;
    assign stp_chk_en   = state_q == STOP && edge_q == mid;
    assign data_valid   = dv_q;
`ifdef UART_RX_FSM_FRAME_ERR_EN
    assign frame_err    = fe_q;
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: table-driven and randomized frame checks for uart_rx_fsm
module tb_uart_rx_fsm;
    localparam int DS = 8;
    localparam int NH = 11;
    localparam int NT = NH + 30;
`ifdef UART_RX_FSM_FRAME_ERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif
    typedef struct {
        int p;
        bit pe, g, perr, serr, b2b;
        int exp_len;
        bit exp_dv;
    } vec_t;
    logic clk = 1'b0, rst, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [5:0] prescale, edge_cnt;
    logic dat_samp_en, strt_chk_en, deser_en, par_check_en, stp_chk_en, data_valid, fe;
    logic [12:0] outv;
    int tests = 0, fails = 0, cyc = 0;
    vec_t tbl[NT];
    uart_rx_fsm #(.Data_size(DS)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
        .deser_en(deser_en), .par_check_en(par_check_en), .stp_chk_en(stp_chk_en),
`ifdef UART_RX_FSM_FRAME_ERR_EN
        .data_valid(data_valid), .frame_err(fe)
`else
        .data_valid(data_valid)
`endif
    );
`ifndef UART_RX_FSM_FRAME_ERR_EN
    assign fe = 1'b0;
`endif
    assign outv = {edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_check_en, stp_chk_en, data_valid, fe};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // Expected outputs at cycle t of a frame (t=0 is the first START cycle),
    // derived from bit slots of prescale cycles each.
    function automatic logic [12:0] model(input vec_t v, input int t, input int len, input int m);
        int b, e;
        bit err;
        if (t >= len) begin
            err = (v.pe && v.perr) || v.serr;
            return {6'd0, 1'b0, 4'b0, !v.g && !err, FE_ON && !v.g && err};
        end
        b = t / v.p;
        e = t % v.p;
        return {6'(e), 1'b1, b == 0 && e == m, b >= 1 && b <= DS && e == m,
                v.pe && b == DS + 1 && e == m, b == DS + 1 + int'(v.pe) && e == m, 1'b0, 1'b0};
    endfunction
    task automatic run_frame(input int idx, input vec_t v, input bit chained, input int np, input bit npe,
                             output int len, output bit dv_seen, output int dv_cyc);
        int m, fl, bad, first_t;
        logic [12:0] exp_v, fa, fx;
        m  = v.p / 2 + 2;
        fl = v.g ? m + 2 : v.p * (DS + 2 + int'(v.pe));
        if (!chained) begin
            RX_IN = 1'b1;
            prescale = 6'(v.p);
            PAR_EN = v.pe;
            repeat (2) @(negedge clk);
            RX_IN = 1'b0;
        end
        @(negedge clk);
        len = -1; dv_seen = 1'b0; dv_cyc = -1; bad = 0; first_t = -1; fa = '0; fx = '0;
        for (int t = 0; t <= fl; t++) begin
            exp_v = model(v, t, fl, m);
            if (outv !== exp_v) begin
                bad++;
                if (first_t < 0) begin first_t = t; fa = outv; fx = exp_v; end
            end
            if (len < 0 && t > 0 && !dat_samp_en) len = t;
            if (data_valid) begin dv_seen = 1'b1; dv_cyc = cyc; end
            strt_glitch = v.g && t == m + 1;
            par_err = v.perr && v.pe && t == v.p * (DS + 1) + m + 1;
            stp_err = v.serr && t == v.p * (DS + 1 + int'(v.pe)) + m + 1;
            if (t == fl) begin
                RX_IN = !v.b2b;
                prescale = 6'(np);
                PAR_EN = npe;
            end else begin
                RX_IN = 1'($urandom);
                prescale = 6'($urandom);
                PAR_EN = 1'($urandom);
                @(negedge clk);
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL frame%0d_trace: %0d bad cycles, first t=%0d got %h expected %h", idx, bad, first_t, fa, fx);
        end
    endtask
    initial begin
        int len, dvc, bad, k;
        bit dv;
        int dvcs[NT];
        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #1 check("reset_outputs", int'(outv), 0);
        repeat (3) @(negedge clk);
        check("reset_hold", int'(outv), 0);
        rst = 1'b1;
        tbl[0]  = '{8,  1, 0, 0, 0, 0, 88,  1};
        tbl[1]  = '{16, 0, 0, 0, 0, 0, 160, 1};
        tbl[2]  = '{8,  1, 1, 0, 0, 0, 8,   0};
        tbl[3]  = '{8,  1, 0, 1, 0, 0, 88,  0};
        tbl[4]  = '{8,  1, 0, 0, 0, 0, 88,  1};
        tbl[5]  = '{8,  1, 0, 0, 0, 1, 88,  1};
        tbl[6]  = '{8,  1, 0, 0, 0, 0, 88,  1};
        tbl[7]  = '{16, 1, 1, 0, 0, 1, 12,  0};
        tbl[8]  = '{32, 1, 0, 0, 1, 0, 352, 0};
        tbl[9]  = '{32, 0, 0, 0, 0, 0, 320, 1};
        tbl[10] = '{8,  0, 0, 0, 1, 0, 80,  0};
        for (int i = NH; i < NT; i++) begin
            k = int'($urandom_range(0, 2));
            tbl[i].p = 8 << k;
            tbl[i].pe = 1'($urandom);
            tbl[i].g = $urandom_range(0, 4) == 0;
            tbl[i].perr = $urandom_range(0, 3) == 0;
            tbl[i].serr = $urandom_range(0, 3) == 0;
            tbl[i].b2b = (i != NT - 1) && 1'($urandom);
            tbl[i].exp_len = tbl[i].g ? tbl[i].p / 2 + 4 : tbl[i].p * (DS + 2 + int'(tbl[i].pe));
            tbl[i].exp_dv = !tbl[i].g && !(tbl[i].pe && tbl[i].perr) && !tbl[i].serr;
        end
        for (int i = 0; i < NT; i++) begin
            run_frame(i, tbl[i], i > 0 && tbl[i > 0 ? i - 1 : 0].b2b,
                      i + 1 < NT ? tbl[i + 1 < NT ? i + 1 : i].p : 8,
                      i + 1 < NT ? tbl[i + 1 < NT ? i + 1 : i].pe : 1'b0, len, dv, dvc);
            check($sformatf("frame%0d_len", i), len, tbl[i].exp_len);
            check($sformatf("frame%0d_data_valid", i), int'(dv), int'(tbl[i].exp_dv));
            dvcs[i] = dvc;
        end
        check("b2b_dv_spacing", dvcs[6] - dvcs[5], 89);
        prescale = 6'd8; PAR_EN = 1'b1; RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        RX_IN = 1'b0;
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (35) @(negedge clk);
        check("busy_before_reset", int'(dat_samp_en), 1);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", int'(outv), 0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (outv != 0) bad++;
        end
        check("idle_after_reset", bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
